// File: rtl/fifoout_unpack.sv
// Two-entry prefetch buffer that unpacks IN_WIDTH words into OUT_WIDTH beats, show-ahead on the read side.
// Define FIFOOUT_UNPACK_MSB_FIRST_EN to emit the most significant lane first (LSB-first otherwise).
module fifoout_unpack #(
    parameter int IN_WIDTH  = 256,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [IN_WIDTH-1:0]  wr_data,
    output logic                 wr_vld,
    output logic                 wr_ovf,
    input  logic                 rd_en,
    output logic                 rd_vld,
    output logic [OUT_WIDTH-1:0] rd_data,
    output logic                 rd_last,
    output logic [1:0]           word_cnt
);

    localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
    localparam int BEAT_W = $clog2(RATIO);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

    logic [IN_WIDTH-1:0] mem [2];
    logic                wptr;
    logic                rptr;
    logic [1:0]          cnt;
    logic [BEAT_W-1:0]   beat;
    logic [BEAT_W-1:0]   sel;
    logic                wr_fire;
    logic                rd_fire;
    logic                rd_retire;

    // Flags decode registered state only, so wr_vld has no path from rd_en.
    assign wr_vld    = (cnt != 2'd2);
    assign rd_vld    = (cnt != 2'd0);
    assign rd_last   = rd_vld & (beat == LAST_BEAT);
    assign word_cnt  = cnt;
    assign wr_fire   = wr_en & wr_vld;
    assign rd_fire   = rd_en & rd_vld;
    assign rd_retire = rd_fire & rd_last;

    // NOTE: data storage carries no reset; only the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wptr] <= wr_data;
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            cnt    <= 2'd0;
            beat   <= '0;
            wr_ovf <= 1'b0;
        end else begin
            if (wr_fire) wptr <= ~wptr;
            if (rd_fire) begin
                if (rd_last) begin
                    beat <= '0;
                    rptr <= ~rptr;
                end else begin
                    beat <= beat + BEAT_W'(1);
                end
            end
            if (wr_fire && !rd_retire)      cnt <= cnt + 2'd1;
            else if (!wr_fire && rd_retire) cnt <= cnt - 2'd1;
            if (wr_en && !wr_vld) wr_ovf <= 1'b1;
        end
    end

    // rd_data is deliberately left ungated while rd_vld is low.
    always_comb begin
        // NOTE: default assignment first so no path leaves sel unassigned (no latch).
        sel = beat;
`ifdef FIFOOUT_UNPACK_MSB_FIRST_EN
        sel = LAST_BEAT - beat;
`endif
        rd_data = mem[rptr][sel*OUT_WIDTH +: OUT_WIDTH];
    end

endmodule
